// File: rtl/alu_issue_ctrl.sv
// Issue controller: decodes one MIPS instruction, drives the ALU and returns a result bundle.
// Latency: res_valid is asserted 3 cycles after the accept. The result is held until res_ready; one instruction per 4 cycles at most.
module alu_issue_ctrl #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [31:0]   instr,
  output logic [RW-1:0] rs_addr,
  output logic [RW-1:0] rt_addr,
  input  logic [DW-1:0] rs_data,
  input  logic [DW-1:0] rt_data,
  output logic [DW-1:0] alu_in1,
  output logic [DW-1:0] alu_in2,
  output logic [2:0]    alu_ctrl,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_zero,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic [DW-1:0] res_store,
  output logic [RW-1:0] res_dest,
  output logic          res_wb_en,
  output logic          res_mem_rd,
  output logic          res_mem_wr,
  output logic          res_branch_taken,
  output logic          res_illegal
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, RESP} state_t;

  state_t          state, state_nx;
  logic [31:0]     instr_q;

  // decoded fields, registered in DECODE and consumed in EXEC
  logic [RW-1:0]   dest_q;
  logic            wb_q, mrd_q, mwr_q, beq_q, ill_q, eq_q;
  logic [DW-1:0]   store_q;

  logic [DW-1:0]   d_in1, d_in2;
  logic [2:0]      d_ctrl;
  logic [RW-1:0]   d_dest;
  logic            d_wb, d_mrd, d_mwr, d_beq, d_ill;

  logic [5:0]      opcode, funct;
  logic [DW-1:0]   imm_sext, shamt_zext;

  // The ALU zero flag is redundant: the controller's own equality compare decides beq.
  logic            unused_alu_zero;
  assign unused_alu_zero = alu_zero;

  assign opcode     = instr_q[31:26];
  assign funct      = instr_q[5:0];
  assign rs_addr    = instr_q[25:21];
  assign rt_addr    = instr_q[20:16];
  assign imm_sext   = {{(DW-16){instr_q[15]}}, instr_q[15:0]};
  assign shamt_zext = DW'(instr_q[10:6]);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    instr_ready = 1'b0;
    res_valid   = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nx = DECODE;
      end
      DECODE: state_nx = EXEC;
      EXEC:   state_nx = RESP;
      RESP: begin
        res_valid = 1'b1;
        if (res_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    d_in1  = rs_data;
    d_in2  = rt_data;
    d_ctrl = 3'b000;
    d_dest = instr_q[15:11];
    d_wb   = 1'b0;
    d_mrd  = 1'b0;
    d_mwr  = 1'b0;
    d_beq  = 1'b0;
    d_ill  = 1'b1;
    case (opcode)
      6'h00: begin
        d_wb  = 1'b1;
        d_ill = 1'b0;
        case (funct)
          6'h20: d_ctrl = 3'b000;
          6'h24: d_ctrl = 3'b011;
          6'h27: d_ctrl = 3'b100;
          6'h2A: d_ctrl = 3'b111;
          6'h00: begin
            d_ctrl = 3'b101;
            d_in1  = rt_data;
            d_in2  = shamt_zext;
          end
          default: begin
            d_wb  = 1'b0;
            d_ill = 1'b1;
          end
        endcase
      end
      6'h23: begin
        d_ctrl = 3'b001;
        d_in2  = imm_sext;
        d_dest = instr_q[20:16];
        d_wb   = 1'b1;
        d_mrd  = 1'b1;
        d_ill  = 1'b0;
      end
      6'h2B: begin
        // stores only use the ALU for address generation
        d_ctrl = 3'b001;
        d_in2  = imm_sext;
        d_mwr  = 1'b1;
        d_ill  = 1'b0;
      end
      6'h04: begin
        d_ctrl = 3'b110;
        d_beq  = 1'b1;
        d_ill  = 1'b0;
      end
      default: d_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q          <= '0;
      alu_in1          <= '0;
      alu_in2          <= '0;
      alu_ctrl         <= 3'b000;
      dest_q           <= '0;
      wb_q             <= 1'b0;
      mrd_q            <= 1'b0;
      mwr_q            <= 1'b0;
      beq_q            <= 1'b0;
      ill_q            <= 1'b0;
      eq_q             <= 1'b0;
      store_q          <= '0;
      res_data         <= '0;
      res_store        <= '0;
      res_dest         <= '0;
      res_wb_en        <= 1'b0;
      res_mem_rd       <= 1'b0;
      res_mem_wr       <= 1'b0;
      res_branch_taken <= 1'b0;
      res_illegal      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (instr_valid) instr_q <= instr;
        DECODE: begin
          // an illegal instruction leaves the ALU inputs untouched
          if (!d_ill) begin
            alu_in1  <= d_in1;
            alu_in2  <= d_in2;
            alu_ctrl <= d_ctrl;
          end
          dest_q  <= d_wb ? d_dest : '0;
          wb_q    <= d_wb;
          mrd_q   <= d_mrd;
          mwr_q   <= d_mwr;
          beq_q   <= d_beq;
          ill_q   <= d_ill;
          eq_q    <= (rs_data == rt_data);
          store_q <= rt_data;
        end
        EXEC: begin
          res_data         <= ill_q ? '0 : alu_out;
          res_store        <= mwr_q ? store_q : '0;
          res_dest         <= dest_q;
          res_wb_en        <= wb_q;
          res_mem_rd       <= mrd_q;
          res_mem_wr       <= mwr_q;
          res_branch_taken <= beq_q & eq_q;
          res_illegal      <= ill_q;
        end
        default: ;
      endcase
    end
  end

endmodule
